idli_mem_arb_m: RTL and testbench
=================================

Name: idli_mem_arb_m

Overview:
- Controller and arbiter in front of the SQI memory interface block.
- Shares the single SQI channel between two requesters:
  - the instruction fetch stream, which is the default owner;
  - the load/store unit (LSU), which makes single 16b word accesses.
- Mirrors the SQI transaction state, supplies address and write-data nibbles, and drives redirect and wr_en.
- Masks and routes the returned 16b words to the correct requester.

Parameters:
- RESET_PC, 16'h0000, word address fetched first after reset.

Ports:
- i_arb_gck  in  1  GCK, the core clock.
- i_arb_rst  in  1  asynchronous active-high reset.
- i_arb_ctr  in  2  GCK phase counter; a period is ctr 0..3.
- i_arb_br_vld  in  1  fetch redirect (taken branch).
- i_arb_br_addr  in  16  branch target word address.
- o_arb_instr_vld  out  1  forwarded instruction valid to decode.
- i_arb_lsu_req  in  1  LSU request; held high until o_arb_lsu_done.
- i_arb_lsu_wr  in  1  1=store, 0=load; stable while req is high.
- i_arb_lsu_addr  in  16  LSU word address; stable while req is high.
- i_arb_lsu_wdata  in  16  store data; stable while req is high.
- o_arb_lsu_done  out  1  one-GCK pulse when the access completes.
- o_arb_lsu_rdata  out  16  load data; valid with done on a load, held afterwards.
- o_arb_sqi_redirect  out  1  to SQI redirect.
- o_arb_sqi_wr_en  out  1  to SQI wr_en.
- o_arb_sqi_slice  out  4  nibble to SQI input slice.
- i_arb_sqi_instr  in  16  16b word from SQI.
- i_arb_sqi_instr_vld  in  1  word-complete strobe from SQI.

Behaviour:
- State register st_q:
  - States: RESET, INSTR, ADDR_HI, ADDR_LO, DUMMY, DATA.
  - Advances only when ctr==3, in lockstep with SQI.
  - Transitions:
    - RESET→INSTR→ADDR_HI→ADDR_LO.
    - ADDR_LO→DATA if wr_en, else →DUMMY.
    - DUMMY→DATA.
    - DATA→RESET if redirect, else DATA.
- Other registers:
  - owner_q ∈ {FETCH, LSU}.
  - fetch_pc_q[15:0].
  - br_pend_q.
  - lsu_beat_q, which marks that the LSU data period has completed.
- Reset values:
  - st_q=RESET, owner_q=FETCH, fetch_pc_q=RESET_PC, br_pend_q=0.
  - All outputs 0; o_arb_lsu_rdata=0.
- Address phase (st_q==INSTR): o_arb_sqi_slice = addr[4*ctr +: 4], giving nibble 0 at ctr 0. addr is fetch_pc_q when owner_q==FETCH, else lsu_addr.
- Write data phase (st_q==ADDR_LO): o_arb_sqi_slice = lsu_wdata[4*ctr +: 4] when owner_q==LSU and lsu_wr; otherwise 0.
- o_arb_sqi_slice = 0 in all other states.
- o_arb_sqi_wr_en = (owner_q==LSU && lsu_wr). It is held for the whole transaction and is 0 for fetch.
- Branch handling:
  - br_vld in any cycle loads fetch_pc_q=br_addr and sets br_pend_q.
  - br_vld in the same cycle as a pc increment takes priority over the increment.
- Fetch forwarding:
  - o_arb_instr_vld = sqi_instr_vld && owner_q==FETCH && !br_pend_q && !br_vld.
  - Each forwarded vld increments fetch_pc_q by 1, wrapping 16'hFFFF→0.
- Redirect, combinational; asserted only in DATA:
  - owner FETCH: redirect = br_pend_q || br_vld || lsu_req.
  - owner LSU: redirect = 1 in the first DATA period, so there is exactly one word per LSU access.
- Decision at ctr==3 in DATA with redirect set; the new owner takes effect from RESET:
  - owner FETCH and lsu_req → owner_q=LSU. LSU wins over a pending branch; the branch stays pending and fetch_pc_q holds the target.
  - owner FETCH, else → owner FETCH; clear br_pend_q.
  - owner LSU → owner_q=FETCH; clear br_pend_q.
- LSU completion: o_arb_lsu_done pulses at ctr==3 of the LSU DATA period, i.e. with sqi_instr_vld.
  - Load: o_arb_lsu_rdata captures i_arb_sqi_instr on that cycle.
  - Store: rdata is unchanged.
- Fetch resumes at fetch_pc_q after an LSU access, with no fetch word lost: a word that arrives with a redirect is still forwarded if not masked.
- lsu_req dropped before owner switch: ignored. Dropping after the switch is illegal (assertion).
- Reset asserted mid-transaction: all state returns immediately to reset values; SQI must be reset together.

Test Plan:
- Reset, RESET_PC=16'h0010, no requests:
  - first redirect=0, first address nibbles 0,1,0,0;
  - o_arb_instr_vld once per period from the first DATA period;
  - fetch_pc increments 0x10→0x11→0x12.
- br_vld with br_addr=16'h1234 mid-DATA:
  - instr_vld masked from that cycle;
  - redirect high through ctr==3;
  - next INSTR drives nibbles 4,3,2,1.
- LSU load, addr=16'h00A5, during fetch at pc=0x20:
  - owner switch, wr_en=0, DUMMY visited;
  - done pulse with rdata=sqi_instr (bench returns 16'hBEEF);
  - fetch restarts at pc 0x20 (or 0x21 if the word was forwarded);
  - no instr_vld during LSU.
- LSU store, wdata=16'hC3A9:
  - wr_en=1 from RESET to done, DUMMY skipped;
  - ADDR_LO nibbles 9,A,3,C;
  - done after one DATA period; rdata unchanged.
- Same-cycle br_vld and lsu_req:
  - LSU served first;
  - fetch then restarts at the branch target;
  - no stale instruction forwarded.
- fetch_pc=16'hFFFF: the next forwarded word wraps pc to 16'h0000; async reset asserted during ADDR_HI returns all outputs to reset values within the same cycle.

Source files
------------

// File: rtl/idli_mem_arb_m_if.sv
// idli_mem_arb_m_if: fetch, LSU and SQI signals of the memory arbiter
interface idli_mem_arb_m_if;
  logic [1:0]  i_arb_ctr;
  logic        i_arb_br_vld;
  logic [15:0] i_arb_br_addr;
  logic        o_arb_instr_vld;
  logic        i_arb_lsu_req;
  logic        i_arb_lsu_wr;
  logic [15:0] i_arb_lsu_addr;
  logic [15:0] i_arb_lsu_wdata;
  logic        o_arb_lsu_done;
  logic [15:0] o_arb_lsu_rdata;
  logic        o_arb_sqi_redirect;
  logic        o_arb_sqi_wr_en;
  logic [3:0]  o_arb_sqi_slice;
  logic [15:0] i_arb_sqi_instr;
  logic        i_arb_sqi_instr_vld;
  modport master (
    input  i_arb_ctr, i_arb_br_vld, i_arb_br_addr, i_arb_lsu_req, i_arb_lsu_wr,
           i_arb_lsu_addr, i_arb_lsu_wdata, i_arb_sqi_instr, i_arb_sqi_instr_vld,
    output o_arb_instr_vld, o_arb_lsu_done, o_arb_lsu_rdata, o_arb_sqi_redirect,
           o_arb_sqi_wr_en, o_arb_sqi_slice
  );
  modport slave (
    output i_arb_ctr, i_arb_br_vld, i_arb_br_addr, i_arb_lsu_req, i_arb_lsu_wr,
           i_arb_lsu_addr, i_arb_lsu_wdata, i_arb_sqi_instr, i_arb_sqi_instr_vld,
    input  o_arb_instr_vld, o_arb_lsu_done, o_arb_lsu_rdata, o_arb_sqi_redirect,
           o_arb_sqi_wr_en, o_arb_sqi_slice
  );
endinterface

// File: rtl/idli_mem_arb_m.sv
// idli_mem_arb_m: shares the SQI channel between instruction fetch and single-word LSU accesses
module idli_mem_arb_m #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic             i_arb_gck,
  input  logic             i_arb_rst,
  idli_mem_arb_m_if.master bus
);
  typedef enum logic [2:0] {ST_RESET, ST_INSTR, ST_ADDR_HI, ST_ADDR_LO, ST_DUMMY, ST_DATA} st_t;
  typedef enum logic {OWN_FETCH, OWN_LSU} own_t;
  st_t         st_q;
  own_t        owner_q;
  logic [15:0] fetch_pc_q;
  logic [15:0] rdata_q;
  logic        br_pend_q;
  logic        lsu_beat_q;
  logic        tick;
  logic        lsu;
  logic        wr;
  logic        redirect;
  logic        done;
  logic        fwd;
  logic        to_lsu;
  logic [15:0] addr;
  // Mirror of the SQI transaction: address/data nibbles, redirect, masking and LSU completion
  always_comb begin
    tick = bus.i_arb_ctr == 2'd3;
    lsu = owner_q == OWN_LSU;
    wr = lsu && bus.i_arb_lsu_wr;
    addr = lsu ? bus.i_arb_lsu_addr : fetch_pc_q;
    redirect = st_q == ST_DATA && (lsu ? !lsu_beat_q : br_pend_q || bus.i_arb_br_vld || bus.i_arb_lsu_req);
    to_lsu = !lsu && bus.i_arb_lsu_req;
    done = st_q == ST_DATA && lsu && tick && !lsu_beat_q;
    fwd = bus.i_arb_sqi_instr_vld && !lsu && !br_pend_q && !bus.i_arb_br_vld;
    bus.o_arb_sqi_slice = st_q == ST_INSTR ? addr[{bus.i_arb_ctr, 2'b00} +: 4] :
                          st_q == ST_ADDR_LO && wr ? bus.i_arb_lsu_wdata[{bus.i_arb_ctr, 2'b00} +: 4] : 4'h0;
    bus.o_arb_sqi_wr_en = wr;
    bus.o_arb_sqi_redirect = redirect;
    bus.o_arb_instr_vld = fwd;
    bus.o_arb_lsu_done = done;
    bus.o_arb_lsu_rdata = done && !bus.i_arb_lsu_wr ? bus.i_arb_sqi_instr : rdata_q;
  end
  // Transaction state, ownership, fetch pointer and load data, stepped in lockstep with SQI
  always_ff @(posedge i_arb_gck or posedge i_arb_rst)
    if (i_arb_rst) begin
      st_q <= ST_RESET;
      owner_q <= OWN_FETCH;
      fetch_pc_q <= RESET_PC;
      br_pend_q <= 1'b0;
      lsu_beat_q <= 1'b0;
      rdata_q <= 16'h0000;
    end else begin
      if (tick)
        st_q <= st_q == ST_RESET ? ST_INSTR :
                st_q == ST_INSTR ? ST_ADDR_HI :
                st_q == ST_ADDR_HI ? ST_ADDR_LO :
                st_q == ST_ADDR_LO ? (wr ? ST_DATA : ST_DUMMY) :
                st_q == ST_DUMMY ? ST_DATA :
                redirect ? ST_RESET : ST_DATA;
      if (tick && redirect)
        owner_q <= to_lsu ? OWN_LSU : OWN_FETCH;
      if (tick && redirect && !to_lsu)
        br_pend_q <= 1'b0;
      else if (bus.i_arb_br_vld)
        br_pend_q <= 1'b1;
      fetch_pc_q <= bus.i_arb_br_vld ? bus.i_arb_br_addr : fwd ? fetch_pc_q + 16'd1 : fetch_pc_q;
      lsu_beat_q <= done || (lsu_beat_q && st_q != ST_RESET);
      if (done && !bus.i_arb_lsu_wr)
        rdata_q <= bus.i_arb_sqi_instr;
    end
  // The LSU must keep its request up for the whole access it owns
  assert property (@(posedge i_arb_gck) disable iff (i_arb_rst) lsu |-> bus.i_arb_lsu_req);
endmodule

// File: tb/tb_idli_mem_arb_m.sv
// tb_idli_mem_arb_m: directed period-by-period checks of the SQI memory arbiter
module tb_idli_mem_arb_m;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] p_slice;
  logic [15:0] p_rdata;
  logic [3:0]  p_redir;
  logic [3:0]  p_vld;
  logic [3:0]  p_done;
  logic [3:0]  p_wr;
  idli_mem_arb_m_if bus();
  idli_mem_arb_m #(.RESET_PC(16'h0010)) dut (.i_arb_gck(clk), .i_arb_rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic period(input logic vld, input int br_at, input logic [15:0] baddr, input logic [15:0] word);
    for (int c = 0; c < 4; c++) begin
      bus.i_arb_ctr = 2'(c);
      bus.i_arb_br_vld = c == br_at;
      bus.i_arb_br_addr = baddr;
      bus.i_arb_sqi_instr_vld = vld && c == 3;
      bus.i_arb_sqi_instr = word;
      #2;
      p_slice[4*c +: 4] = bus.o_arb_sqi_slice;
      p_redir[c] = bus.o_arb_sqi_redirect;
      p_vld[c] = bus.o_arb_instr_vld;
      p_done[c] = bus.o_arb_lsu_done;
      p_wr[c] = bus.o_arb_sqi_wr_en;
      if (c == 3) p_rdata = bus.o_arb_lsu_rdata;
      @(posedge clk);
      #1;
    end
    bus.i_arb_br_vld = 1'b0;
    bus.i_arb_sqi_instr_vld = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) period(1'b0, -1, 16'h0, 16'h0);
  endtask
  initial begin
    bus.i_arb_ctr = 2'd0;
    bus.i_arb_br_vld = 1'b0;
    bus.i_arb_br_addr = 16'h0;
    bus.i_arb_lsu_req = 1'b0;
    bus.i_arb_lsu_wr = 1'b0;
    bus.i_arb_lsu_addr = 16'h0;
    bus.i_arb_lsu_wdata = 16'h0;
    bus.i_arb_sqi_instr = 16'h0;
    bus.i_arb_sqi_instr_vld = 1'b0;
    @(posedge clk);
    #3;
    chk("rst_out", {bus.o_arb_instr_vld, bus.o_arb_lsu_done, bus.o_arb_sqi_redirect, bus.o_arb_sqi_wr_en, bus.o_arb_sqi_slice}, 0);
    chk("rst_rdata", bus.o_arb_lsu_rdata, 0);
    chk("rst_pc", dut.fetch_pc_q, 16'h0010);
    rst = 1'b0;
    idle(1);
    chk("first_redir", p_redir, 0);
    idle(1);
    chk("first_nib", p_slice, 16'h0010);
    idle(2);
    chk("fetch_addrlo", {p_wr, p_slice}, 0);
    idle(1);
    period(1'b1, -1, 16'h0, 16'h1111);
    chk("fetch_vld0", p_vld, 4'b1000);
    chk("fetch_redir0", p_redir, 0);
    chk("pc_11", dut.fetch_pc_q, 16'h0011);
    period(1'b1, -1, 16'h0, 16'h1112);
    chk("fetch_vld1", p_vld, 4'b1000);
    chk("pc_12", dut.fetch_pc_q, 16'h0012);
    period(1'b1, 1, 16'h1234, 16'h2222);
    chk("br_redir", p_redir, 4'b1110);
    chk("br_mask", p_vld, 0);
    chk("br_pc", dut.fetch_pc_q, 16'h1234);
    idle(2);
    chk("br_nib", p_slice, 16'h1234);
    idle(3);
    period(1'b1, -1, 16'h0, 16'h2223);
    chk("br_resume", p_vld, 4'b1000);
    chk("pc_1235", dut.fetch_pc_q, 16'h1235);
    period(1'b1, 0, 16'h0020, 16'h3333);
    chk("br20_mask", p_vld, 0);
    idle(2);
    chk("pc20_nib", p_slice, 16'h0020);
    idle(3);
    bus.i_arb_lsu_req = 1'b1;
    bus.i_arb_lsu_wr = 1'b0;
    bus.i_arb_lsu_addr = 16'h00A5;
    period(1'b1, -1, 16'h0, 16'h4444);
    chk("ld_sw_redir", p_redir, 4'b1111);
    chk("ld_sw_fwd", p_vld, 4'b1000);
    chk("ld_sw_pc", dut.fetch_pc_q, 16'h0021);
    idle(1);
    chk("ld_wr", p_wr, 0);
    idle(1);
    chk("ld_nib", p_slice, 16'h00A5);
    idle(2);
    chk("ld_addrlo", p_slice, 0);
    idle(1);
    chk("ld_dummy", p_done, 0);
    period(1'b1, -1, 16'h0, 16'hBEEF);
    chk("ld_done", p_done, 4'b1000);
    chk("ld_rdata", p_rdata, 16'hBEEF);
    chk("ld_novld", p_vld, 0);
    chk("ld_redir", p_redir, 4'b1111);
    bus.i_arb_lsu_req = 1'b0;
    idle(2);
    chk("ld_resume", p_slice, 16'h0021);
    idle(3);
    bus.i_arb_lsu_req = 1'b1;
    bus.i_arb_lsu_wr = 1'b1;
    bus.i_arb_lsu_addr = 16'h0300;
    bus.i_arb_lsu_wdata = 16'hC3A9;
    period(1'b1, -1, 16'h0, 16'h5555);
    chk("st_sw_fwd", p_vld, 4'b1000);
    idle(1);
    chk("st_wr_rst", p_wr, 4'b1111);
    idle(1);
    chk("st_nib", p_slice, 16'h0300);
    idle(2);
    chk("st_wdata", p_slice, 16'hC3A9);
    chk("st_wr_lo", p_wr, 4'b1111);
    period(1'b1, -1, 16'h0, 16'h6666);
    chk("st_done", p_done, 4'b1000);
    chk("st_rdata", p_rdata, 16'hBEEF);
    chk("st_wr_data", p_wr, 4'b1111);
    bus.i_arb_lsu_req = 1'b0;
    bus.i_arb_lsu_wr = 1'b0;
    idle(1);
    chk("st_wr_off", p_wr, 0);
    idle(1);
    chk("st_resume", p_slice, 16'h0022);
    idle(3);
    bus.i_arb_lsu_req = 1'b1;
    bus.i_arb_lsu_addr = 16'h0007;
    period(1'b1, 0, 16'h4000, 16'h7777);
    chk("both_mask", p_vld, 0);
    idle(2);
    chk("both_lsu_first", p_slice, 16'h0007);
    idle(3);
    period(1'b1, -1, 16'h0, 16'h0BAD);
    chk("both_done", p_done, 4'b1000);
    chk("both_rdata", p_rdata, 16'h0BAD);
    chk("both_novld", p_vld, 0);
    bus.i_arb_lsu_req = 1'b0;
    idle(2);
    chk("both_target", p_slice, 16'h4000);
    idle(3);
    period(1'b1, -1, 16'h0, 16'h8888);
    chk("both_fwd", p_vld, 4'b1000);
    chk("pc_4001", dut.fetch_pc_q, 16'h4001);
    period(1'b0, 0, 16'hFFFF, 16'h0);
    idle(2);
    chk("ffff_nib", p_slice, 16'hFFFF);
    idle(3);
    period(1'b1, -1, 16'h0, 16'h9999);
    chk("wrap_vld", p_vld, 4'b1000);
    chk("wrap_pc", dut.fetch_pc_q, 16'h0000);
    bus.i_arb_lsu_req = 1'b1;
    bus.i_arb_lsu_wr = 1'b1;
    bus.i_arb_lsu_addr = 16'h0001;
    bus.i_arb_lsu_wdata = 16'h0;
    idle(3);
    bus.i_arb_ctr = 2'd0;
    #2;
    chk("hi_wr_pre", bus.o_arb_sqi_wr_en, 1);
    rst = 1'b1;
    #1;
    chk("hi_rst_out", {bus.o_arb_instr_vld, bus.o_arb_lsu_done, bus.o_arb_sqi_redirect, bus.o_arb_sqi_wr_en, bus.o_arb_sqi_slice}, 0);
    chk("hi_rst_rdata", bus.o_arb_lsu_rdata, 0);
    chk("hi_rst_pc", dut.fetch_pc_q, 16'h0010);
    bus.i_arb_lsu_req = 1'b0;
    bus.i_arb_lsu_wr = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    chk("re_redir", {p_redir, p_wr}, 0);
    idle(1);
    chk("re_nib", p_slice, 16'h0010);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
